relu_vec_serializer: RTL and testbench
======================================

Name: relu_vec_serializer

Overview:
- Reads the registered activation vector that a ReLU layer produces (`zin[NUM_NODES]` plus a one-cycle `i_valid` pulse).
- Streams the vector one element per beat over a valid/ready interface to the next dense layer's MAC.
- Holds a two-slot vector buffer, so one vector can be captured while the previous one is still streaming. The producer pulse has no backpressure.

Parameters:
- DATA_WIDTH, 32, bit width of each activation element.
- NUM_NODES, 20, elements per vector (>=2).
- IDX_WIDTH, $clog2(NUM_NODES), width of the element index output.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- i_valid  input  1  one-cycle pulse; `zin` is valid this cycle.
- zin  input  DATA_WIDTH x NUM_NODES  parallel activation vector.
- o_valid  output  1  stream beat valid.
- o_data  output  DATA_WIDTH  current element.
- o_idx  output  IDX_WIDTH  index of current element within its vector.
- o_last  output  1  current beat is index NUM_NODES-1.
- i_ready  input  1  downstream accepts the beat when `o_valid && i_ready`.
- o_space  output  1  high when count < 2 (a capture would be accepted); advisory only.
- o_overflow  output  1  sticky; a vector was dropped.

Behaviour:
- Reset (rst low, async): count=0, wr_slot=0, rd_slot=0, elem=0, o_overflow=0. Outputs: o_valid=0, o_idx=0, o_last=0, o_space=1. o_data is don't-care while o_valid=0 but must be X-free; it reads slot0[0], which is reset to 0.
- Storage: two slots of NUM_NODES x DATA_WIDTH registers, plus wr_slot, rd_slot, count (0..2) and an element counter elem (0..NUM_NODES-1).
- Capture:
  - Condition: i_valid=1 and (count<2, or a retire occurs this same cycle).
  - Action: zin is written into slot[wr_slot] at the clock edge, and wr_slot toggles.
- Drop:
  - Condition: i_valid=1 with count=2 and no retire this cycle.
  - Action: vector discarded, o_overflow set to 1 until reset; buffer state unchanged.
- Stream FSM states:
  - IDLE (count=0): o_valid=0.
  - STREAM (count>0): o_valid=1, o_data=slot[rd_slot][elem], o_idx=elem, o_last=(elem==NUM_NODES-1).
- Beat transfer (o_valid && i_ready):
  - Not last element: elem++.
  - Last element (retire): elem=0, rd_slot toggles, count decrements.
- Simultaneous capture and retire: count unchanged. The freed slot may be the capture target; this is accepted, and the write and the read of different slots do not conflict.
- Latency: capture at edge N gives o_valid=1 with elem 0 in cycle N+1. With i_ready tied high, one vector takes NUM_NODES cycles, and back-to-back vectors stream with no bubble.
- Stability: while o_valid=1 and i_ready=0, o_data, o_idx and o_last hold stable.
- Reset mid-stream: partial vector and buffered vector are lost; all state returns to reset values immediately.
- o_space = (count<2), combinational from registered count.

Optional Feature:
- Macro: SERIALIZER_SKIP_ZERO_EN.
- When defined (ReLU outputs are sparse):
  - Element with value 0 and elem<NUM_NODES-1: o_valid=0 for that cycle and elem advances unconditionally (one cycle per skipped element, independent of i_ready).
  - Index NUM_NODES-1 is always presented, even if zero, so every vector produces exactly one o_last beat.
  - o_idx reports the true element index of each presented beat.
- When undefined: every element is presented, as described in Behaviour.

Test Plan:
- Basic stream: NUM_NODES=4, DATA_WIDTH=8, i_ready=1; pulse i_valid with zin={5,0,7,9}. Required: beats 5,0,7,9 in cycles N+1..N+4, o_idx 0..3, o_last only on value 9, then o_valid=0.
- Backpressure: same vector; drop i_ready for 3 cycles during idx 1. Required: o_data=0 and o_idx=1 held stable; stream resumes with 7 then 9; no beat lost or duplicated.
- Double buffer and overflow: i_ready=0; pulse vectors A={1,2,3,4}, B={5,6,7,8}, C={9,9,9,9}. Required: o_space=0 after B; C dropped and o_overflow=1; release i_ready gives 1..4 then 5..8 with no bubble; o_overflow stays 1.
- Simultaneous capture and retire: count=2 and i_valid pulses in the same cycle the last beat of A is accepted. Required: new vector accepted, o_overflow stays 0, streams after B.
- Async reset mid-stream: assert rst low at idx 2. Required: o_valid=0 without waiting for a clock edge, and o_overflow=0. After release, a new pulse streams from idx 0.
- SERIALIZER_SKIP_ZERO_EN defined, zin={0,3,0,0}: beats idx1=3 and idx3=0 (o_last) only; all-zero vector yields a single beat idx3=0 with o_last=1.

Source files
------------

// File: rtl/relu_vec_serializer.sv
// relu_vec_serializer
//   Buffers activation vectors from a ReLU layer (two-slot ping-pong store) and
//   streams them one element per beat over a valid/ready interface.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   i_valid    in   one-cycle pulse, zin valid (no backpressure on the producer)
//   zin        in   NUM_NODES x DATA_WIDTH vector, element k at zin[k*DATA_WIDTH +: DATA_WIDTH]
//   o_valid    out  stream beat valid
//   o_data     out  current element
//   o_idx      out  element index within its vector
//   o_last     out  current element is index NUM_NODES-1
//   i_ready    in   downstream accepts the beat when o_valid && i_ready
//   o_space    out  a capture would be accepted (count < 2), advisory
//   o_overflow out  sticky, a vector was dropped
//
// Build option
//   SERIALIZER_SKIP_ZERO_EN : zero elements (except the last index) are not
//   presented; elem advances one per cycle over them regardless of i_ready.

module relu_vec_serializer #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_NODES  = 20,
   parameter int IDX_WIDTH  = $clog2(NUM_NODES)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            i_valid,
   input  logic [NUM_NODES*DATA_WIDTH-1:0] zin,
   output logic                            o_valid,
   output logic [DATA_WIDTH-1:0]           o_data,
   output logic [IDX_WIDTH-1:0]            o_idx,
   output logic                            o_last,
   input  logic                            i_ready,
   output logic                            o_space,
   output logic                            o_overflow
);

   localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(NUM_NODES - 1);

   typedef enum logic {StIdle, StStream} state_t;

   state_t                r_state;
   logic [1:0]            r_count;
   logic                  r_wr_slot;
   logic                  r_rd_slot;
   logic [IDX_WIDTH-1:0]  r_elem;
   logic                  r_overflow;
   logic [DATA_WIDTH-1:0] r_slot [2][NUM_NODES];

   logic [DATA_WIDTH-1:0] w_cur;
   logic                  w_streaming;
   logic                  w_at_last;
   logic                  w_skip;
   logic                  w_fire;
   logic                  w_retire;
   logic                  w_capture;
   logic [1:0]            w_count_d;

   assign w_cur       = r_slot[r_rd_slot][r_elem];
   assign w_streaming = (r_state == StStream);
   assign w_at_last   = (r_elem == LastIdx);

`ifdef SERIALIZER_SKIP_ZERO_EN
   // The last index is always shown so every vector yields exactly one o_last beat.
   assign w_skip = w_streaming && (w_cur == '0) && !w_at_last;
`else
   assign w_skip = 1'b0;
`endif

   assign o_valid    = w_streaming && !w_skip;
   assign o_data     = w_cur;
   assign o_idx      = r_elem;
   assign o_last     = w_streaming && w_at_last;
   assign o_space    = (r_count != 2'd2);
   assign o_overflow = r_overflow;

   assign w_fire    = o_valid && i_ready;
   assign w_retire  = w_fire && w_at_last;
   // A retire frees a slot in the same cycle, so a full buffer can still capture.
   assign w_capture = i_valid && ((r_count != 2'd2) || w_retire);

   always_comb begin
      w_count_d = r_count;
      unique case ({w_capture, w_retire})
         2'b10:   w_count_d = r_count + 2'd1;
         2'b01:   w_count_d = r_count - 2'd1;
         default: w_count_d = r_count;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= StIdle;
         r_count    <= 2'd0;
         r_wr_slot  <= 1'b0;
         r_rd_slot  <= 1'b0;
         r_elem     <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_count <= w_count_d;
         r_state <= (w_count_d != 2'd0) ? StStream : StIdle;

         if (w_capture) begin
            r_wr_slot <= ~r_wr_slot;
         end else if (i_valid) begin
            r_overflow <= 1'b1;
         end

         if (w_retire) begin
            r_elem    <= '0;
            r_rd_slot <= ~r_rd_slot;
         end else if (w_fire || w_skip) begin
            r_elem <= r_elem + IDX_WIDTH'(1);
         end
      end
   end

   // Slot storage; the capture target is never the slot being read unless that
   // slot retires in this same cycle, so write and read do not collide.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < NUM_NODES; k++) begin
               r_slot[s][k] <= '0;
            end
         end
      end else if (w_capture) begin
         for (int k = 0; k < NUM_NODES; k++) begin
            r_slot[r_wr_slot][k] <= zin[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

endmodule

// File: tb/tb_relu_vec_serializer.sv
module tb_relu_vec_serializer;

   localparam int DW = 8;
   localparam int NN = 4;
   localparam int IW = 2;
`ifdef SERIALIZER_SKIP_ZERO_EN
   localparam bit Skip = 1'b1;
`else
   localparam bit Skip = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              i_valid;
   logic [NN*DW-1:0]  zin;
   logic              o_valid;
   logic [DW-1:0]     o_data;
   logic [IW-1:0]     o_idx;
   logic              o_last;
   logic              i_ready;
   logic              o_space;
   logic              o_overflow;

   relu_vec_serializer #(.DATA_WIDTH(DW), .NUM_NODES(NN), .IDX_WIDTH(IW)) dut (
      .clk       (clk),
      .rst       (rst),
      .i_valid   (i_valid),
      .zin       (zin),
      .o_valid   (o_valid),
      .o_data    (o_data),
      .o_idx     (o_idx),
      .o_last    (o_last),
      .i_ready   (i_ready),
      .o_space   (o_space),
      .o_overflow(o_overflow)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: queue of whole vectors plus a read position.
   logic [NN*DW-1:0] m_q[$];
   int               m_pos;
   logic             m_ovf;
   logic             e_ne;
   logic             e_valid;
   logic [13:0]      exp_v;
   logic [13:0]      obs_v;

   function automatic logic [NN*DW-1:0] pack(input int a, input int b, input int c, input int d);
      logic [NN*DW-1:0] v;
      v[0*DW +: DW] = DW'(a);
      v[1*DW +: DW] = DW'(b);
      v[2*DW +: DW] = DW'(c);
      v[3*DW +: DW] = DW'(d);
      return v;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_pos = 0;
      m_ovf = 1'b0;
   endtask

   // Apply inputs, move to the falling edge, form expected and observed vectors.
   task automatic drive(input logic v, input logic [NN*DW-1:0] vec, input logic rdy);
      logic [NN*DW-1:0] head;
      logic [DW-1:0]    cur;
      logic [IW-1:0]    eidx;
      logic             elast;
      i_valid = v;
      zin     = vec;
      i_ready = rdy;
      @(negedge clk);
      e_ne    = (m_q.size() != 0);
      head    = e_ne ? m_q[0] : '0;
      cur     = head[m_pos*DW +: DW];
      e_valid = e_ne && (!Skip || (cur != '0) || (m_pos == NN - 1));
      eidx    = e_ne ? IW'(m_pos) : '0;
      elast   = e_ne && (m_pos == NN - 1);
      exp_v   = {e_valid, e_valid ? cur : 8'h00, eidx, elast, (m_q.size() < 2), m_ovf};
      obs_v   = {o_valid, o_valid ? o_data : 8'h00, o_idx, o_last, o_space, o_overflow};
   endtask

   task automatic advance();
      logic fire;
      logic ret;
      int   sz;
      fire = e_valid && i_ready;
      ret  = fire && (m_pos == NN - 1);
      sz   = m_q.size();
      if (fire) begin
         if (ret) begin
            void'(m_q.pop_front());
            m_pos = 0;
         end else begin
            m_pos++;
         end
      end else if (e_ne && !e_valid) begin
         m_pos++;
      end
      if (i_valid) begin
         if (sz < 2 || ret) m_q.push_back(zin);
         else m_ovf = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; i_valid = 1'b0; i_ready = 1'b0; zin = '0;
      model_reset();
      #12;
      n_checks++;
      if ({o_valid, o_idx, o_last, o_space, o_overflow, o_data} !== {1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 8'h00})
         $display("FAIL reset: got v%b i%0d l%b s%b o%b d%h want v0 i0 l0 s1 o0 d00",
                  o_valid, o_idx, o_last, o_space, o_overflow, o_data);
      else n_pass++;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      int beats = 0;
      int lasts = 0;
      drive(1'b1, pack(5, 0, 7, 9), 1'b1);
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL basic_cap: got %h want %h", obs_v, exp_v);
      else n_pass++;
      advance();
      for (int c = 0; c < 5; c++) begin
         drive(1'b0, '0, 1'b1);
         if (o_valid) beats++;
         if (o_valid && o_last) lasts++;
         n_checks++;
         if (obs_v !== exp_v) $display("FAIL basic c%0d: got %h want %h", c, obs_v, exp_v);
         else n_pass++;
         advance();
      end
      n_checks++;
      if (beats != (Skip ? 3 : 4) || lasts != 1)
         $display("FAIL basic_count: got beats %0d lasts %0d want %0d and 1",
                  beats, lasts, Skip ? 3 : 4);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      drive(1'b1, pack(5, 0, 7, 9), 1'b1);
      advance();
      for (int c = 0; c < 8; c++) begin
         drive(1'b0, '0, !(c >= 1 && c <= 3));
         n_checks++;
         if (obs_v !== exp_v) $display("FAIL bp c%0d: got %h want %h", c, obs_v, exp_v);
         else n_pass++;
`ifndef SERIALIZER_SKIP_ZERO_EN
         if (c >= 1 && c <= 4) begin
            n_checks++;
            if (!o_valid || o_data !== 8'd0 || o_idx !== 2'd1)
               $display("FAIL bp_hold c%0d: got v%b d%0d i%0d want v1 d0 i1",
                        c, o_valid, o_data, o_idx);
            else n_pass++;
         end
`endif
         advance();
      end
   endtask

   task automatic test_simul();
      drive(1'b1, pack(1, 2, 3, 4), 1'b0); advance();
      drive(1'b1, pack(5, 6, 7, 8), 1'b0); advance();
      for (int c = 0; c < 3; c++) begin
         drive(1'b0, '0, 1'b1);
         n_checks++;
         if (obs_v !== exp_v) $display("FAIL simul_a c%0d: got %h want %h", c, obs_v, exp_v);
         else n_pass++;
         advance();
      end
      drive(1'b1, pack(11, 12, 13, 14), 1'b1);
      n_checks++;
      if (!(o_valid && o_last && o_space == 1'b0))
         $display("FAIL simul_edge: got v%b l%b s%b want v1 l1 s0", o_valid, o_last, o_space);
      else n_pass++;
      advance();
      for (int c = 0; c < 9; c++) begin
         drive(1'b0, '0, 1'b1);
         n_checks++;
         if (obs_v !== exp_v) $display("FAIL simul_bd c%0d: got %h want %h", c, obs_v, exp_v);
         else n_pass++;
         advance();
      end
      n_checks++;
      if (o_overflow !== 1'b0) $display("FAIL simul_ovf: got %b want 0", o_overflow);
      else n_pass++;
   endtask

   task automatic test_overflow();
      drive(1'b1, pack(1, 2, 3, 4), 1'b0); advance();
      drive(1'b1, pack(5, 6, 7, 8), 1'b0); advance();
      drive(1'b1, pack(9, 9, 9, 9), 1'b0);
      n_checks++;
      if (o_space !== 1'b0) $display("FAIL ovf_space: got %b want 0", o_space);
      else n_pass++;
      advance();
      for (int c = 0; c < 9; c++) begin
         drive(1'b0, '0, 1'b1);
         n_checks++;
         if (obs_v !== exp_v) $display("FAIL ovf c%0d: got %h want %h", c, obs_v, exp_v);
         else n_pass++;
         advance();
      end
      n_checks++;
      if (o_overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", o_overflow);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      drive(1'b1, pack(21, 22, 23, 24), 1'b1); advance();
      drive(1'b0, '0, 1'b1); advance();
      drive(1'b0, '0, 1'b1); advance();
      #2;
      rst = 1'b0;
      #1;
      n_checks++;
      if ({o_valid, o_overflow, o_idx, o_space} !== {1'b0, 1'b0, 2'd0, 1'b1})
         $display("FAIL async_rst: got v%b o%b i%0d s%b want v0 o0 i0 s1",
                  o_valid, o_overflow, o_idx, o_space);
      else n_pass++;
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      drive(1'b1, pack(31, 32, 33, 34), 1'b1); advance();
      for (int c = 0; c < 5; c++) begin
         drive(1'b0, '0, 1'b1);
         n_checks++;
         if (obs_v !== exp_v) $display("FAIL post_rst c%0d: got %h want %h", c, obs_v, exp_v);
         else n_pass++;
         advance();
      end
   endtask

   task automatic test_skip_zero();
      int beats;
      int lasts;
      for (int t = 0; t < 2; t++) begin
         beats = 0;
         lasts = 0;
         drive(1'b1, (t == 0) ? pack(0, 3, 0, 0) : pack(0, 0, 0, 0), 1'b1);
         advance();
         for (int c = 0; c < 6; c++) begin
            drive(1'b0, '0, 1'b1);
            if (o_valid) beats++;
            if (o_valid && o_last) lasts++;
            n_checks++;
            if (obs_v !== exp_v) $display("FAIL skip t%0d c%0d: got %h want %h", t, c, obs_v, exp_v);
            else n_pass++;
            advance();
         end
         n_checks++;
         if (beats != (Skip ? (t == 0 ? 2 : 1) : 4) || lasts != 1)
            $display("FAIL skip_count t%0d: got beats %0d lasts %0d", t, beats, lasts);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      logic [NN*DW-1:0] vec;
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < NN; k++)
            vec[k*DW +: DW] = ($urandom_range(0, 2) == 0) ? 8'h00 : DW'($urandom_range(1, 255));
         drive(($urandom_range(0, 3) == 0), vec, ($urandom_range(0, 3) != 0));
         n_checks++;
         if (obs_v !== exp_v) $display("FAIL rand c%0d: got %h want %h", c, obs_v, exp_v);
         else n_pass++;
         advance();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_simul();
      test_overflow();
      test_async_reset();
      test_skip_zero();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
